// File: rtl/reg_file_mp_if.sv
// Bus bundle for the multi-port register file: read ports, two write lanes and clear/ready control.
interface reg_file_mp_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2
);
    localparam int unsigned ADDR_W = $clog2(NUM_REGS);

    logic                     ClearReq;
    logic                     Ready;
    logic [NUM_RD*ADDR_W-1:0] rs;
    logic [NUM_RD*XLEN-1:0]   ReadData;
    logic                     RegWrite0;
    logic [ADDR_W-1:0]        rd0;
    logic [XLEN-1:0]          WriteData0;
    logic                     RegWrite1;
    logic [ADDR_W-1:0]        rd1;
    logic [XLEN-1:0]          WriteData1;

    modport master (
        output ClearReq, rs, RegWrite0, rd0, WriteData0, RegWrite1, rd1, WriteData1,
        input  Ready, ReadData
    );

    modport slave (
        input  ClearReq, rs, RegWrite0, rd0, WriteData0, RegWrite1, rd1, WriteData1,
        output Ready, ReadData
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port integer register file: NUM_RD combinational read ports, two write lanes,
// x0 hardwired to zero, hardware clear sequencer after reset or on ClearReq.
module reg_file_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned BYPASS   = 1
) (
    input  logic            clk,
    input  logic            rst,
    reg_file_mp_if.slave    bus
);
    localparam int unsigned ADDR_W = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              ready_q, ready_d;
    logic [XLEN-1:0]   mem_q [NUM_REGS];
    logic [XLEN-1:0]   mem_d [NUM_REGS];

    // Sequencer and write path; rst outranks ClearReq, which outranks writes.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready_d   = ready_q;
        mem_d     = mem_q;
        if (rst) begin
            state_d   = ST_CLEAR;
            clr_idx_d = FIRST_IDX;
            ready_d   = 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    mem_d[clr_idx_q] = '0;
                    if (clr_idx_q == LAST_IDX) begin
                        state_d = ST_READY;
                        ready_d = 1'b1;
                    end else begin
                        clr_idx_d = clr_idx_q + ADDR_W'(1);
                    end
                end
                ST_READY: begin
                    if (bus.ClearReq) begin
                        state_d   = ST_CLEAR;
                        clr_idx_d = FIRST_IDX;
                        ready_d   = 1'b0;
                    end else begin
                        // Lane 1 applied last so it wins a same-address conflict.
                        if (bus.RegWrite0 && (bus.rd0 != '0)) mem_d[bus.rd0] = bus.WriteData0;
                        if (bus.RegWrite1 && (bus.rd1 != '0)) mem_d[bus.rd1] = bus.WriteData1;
                    end
                end
                default: begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = FIRST_IDX;
                    ready_d   = 1'b0;
                end
            endcase
        end
        mem_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        clr_idx_q <= clr_idx_d;
        ready_q   <= ready_d;
        mem_q     <= mem_d;
    end

    logic [ADDR_W-1:0]      rd_addr;
    logic [XLEN-1:0]        port_data;
    logic [NUM_RD*XLEN-1:0] read_data;

    // Combinational read ports with optional same-cycle write forwarding.
    always_comb begin
        rd_addr   = '0;
        port_data = '0;
        read_data = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rd_addr   = bus.rs[i*ADDR_W +: ADDR_W];
            port_data = '0;
            if (ready_q && (rd_addr != '0)) begin
                if ((BYPASS != 0) && bus.RegWrite1 && (bus.rd1 == rd_addr)) begin
                    port_data = bus.WriteData1;
                end else if ((BYPASS != 0) && bus.RegWrite0 && (bus.rd0 == rd_addr)) begin
                    port_data = bus.WriteData0;
                end else begin
                    port_data = mem_q[rd_addr];
                end
            end
            read_data[i*XLEN +: XLEN] = port_data;
        end
    end

    assign bus.ReadData = read_data;
    assign bus.Ready    = ready_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: one bypassing and one non-bypassing instance share stimulus.
module tb_reg_file_mp;
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned NRD  = 2;
    localparam int unsigned AW   = 5;

    logic clk;
    logic rst;
    logic clear_req;
    logic [NRD*AW-1:0] rs;
    logic we0, we1;
    logic [AW-1:0] rd0, rd1;
    logic [XLEN-1:0] wd0, wd1;

    reg_file_mp_if #(.XLEN(XLEN), .NUM_REGS(NREG), .NUM_RD(NRD)) bus_b ();
    reg_file_mp_if #(.XLEN(XLEN), .NUM_REGS(NREG), .NUM_RD(NRD)) bus_n ();

    assign bus_b.ClearReq = clear_req;  assign bus_n.ClearReq = clear_req;
    assign bus_b.rs = rs;               assign bus_n.rs = rs;
    assign bus_b.RegWrite0 = we0;       assign bus_n.RegWrite0 = we0;
    assign bus_b.rd0 = rd0;             assign bus_n.rd0 = rd0;
    assign bus_b.WriteData0 = wd0;      assign bus_n.WriteData0 = wd0;
    assign bus_b.RegWrite1 = we1;       assign bus_n.RegWrite1 = we1;
    assign bus_b.rd1 = rd1;             assign bus_n.rd1 = rd1;
    assign bus_b.WriteData1 = wd1;      assign bus_n.WriteData1 = wd1;

    reg_file_mp #(.XLEN(XLEN), .NUM_REGS(NREG), .NUM_RD(NRD), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .bus(bus_b.slave));
    reg_file_mp #(.XLEN(XLEN), .NUM_REGS(NREG), .NUM_RD(NRD), .BYPASS(0)) u_nob (
        .clk(clk), .rst(rst), .bus(bus_n.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            ready;
        logic [NRD*XLEN-1:0] data_byp;
        logic [NRD*XLEN-1:0] data_nob;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: architectural register values plus a clear countdown.
    logic [XLEN-1:0] m_reg [NREG];
    bit              m_known = 0;
    bit              m_ready = 0;
    int              m_left  = 0;

    function automatic logic [XLEN-1:0] model_read(input bit byp, input logic [AW-1:0] a);
        if (!m_ready || a == 0) return '0;
        if (byp && we1 && rd1 == a) return wd1;
        if (byp && we0 && rd0 == a) return wd0;
        return m_reg[a];
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_known = 1; m_ready = 0; m_left = NREG - 1;
        end else if (m_known) begin
            if (!m_ready) begin
                m_left--;
                if (m_left == 0) begin
                    m_ready = 1;
                    for (int i = 0; i < NREG; i++) m_reg[i] = '0;
                end
            end else if (clear_req) begin
                m_ready = 0; m_left = NREG - 1;
            end else begin
                if (we0 && rd0 != 0) m_reg[rd0] = wd0;
                if (we1 && rd1 != 0) m_reg[rd1] = wd1;
            end
        end
    endtask

    task automatic step();
        exp_t e;
        if (m_known) begin
            e.ready = m_ready;
            e.data_byp = '0;
            e.data_nob = '0;
            for (int p = 0; p < NRD; p++) begin
                e.data_byp[p*XLEN +: XLEN] = model_read(1'b1, rs[p*AW +: AW]);
                e.data_nob[p*XLEN +: XLEN] = model_read(1'b0, rs[p*AW +: AW]);
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst = 0; clear_req = 0; we0 = 0; we1 = 0;
        rd0 = '0; rd1 = '0; wd0 = '0; wd1 = '0;
    endtask

    task automatic set_rs(input int p, input int a);
        rs[p*AW +: AW] = AW'(a);
    endtask

    task automatic rand_rs();
        for (int p = 0; p < NRD; p++) set_rs(p, $urandom_range(0, NREG - 1));
    endtask

    task automatic read_all();
        for (int a = 0; a < NREG; a += NRD) begin
            idle();
            for (int p = 0; p < NRD; p++) set_rs(p, (a + p) % NREG);
            step();
        end
    endtask

    // Monitor: compares every presented cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus_b.Ready !== e.ready) begin
                    errors++;
                    $display("FAIL ready_byp t=%0t actual=%b expected=%b", $time, bus_b.Ready, e.ready);
                end
                checks++;
                if (bus_n.Ready !== e.ready) begin
                    errors++;
                    $display("FAIL ready_nob t=%0t actual=%b expected=%b", $time, bus_n.Ready, e.ready);
                end
                checks++;
                if (bus_b.ReadData !== e.data_byp) begin
                    errors++;
                    $display("FAIL rdata_byp t=%0t rs=%h actual=%h expected=%h",
                             $time, rs, bus_b.ReadData, e.data_byp);
                end
                checks++;
                if (bus_n.ReadData !== e.data_nob) begin
                    errors++;
                    $display("FAIL rdata_nob t=%0t rs=%h actual=%h expected=%h",
                             $time, rs, bus_n.ReadData, e.data_nob);
                end
            end
        end
    end

    initial begin
        idle();
        rs = '0;
        rst = 1;
        @(posedge clk);
        #1;
        // T1: reset then clear sequence with random reads
        rst = 1;
        step();
        for (int c = 0; c < 34; c++) begin idle(); rand_rs(); step(); end
        // T2: basic write/read and x0 discard
        idle(); we0 = 1; rd0 = 5; wd0 = 32'hDEADBEEF; set_rs(0, 5); set_rs(1, 0); step();
        idle(); set_rs(0, 5); step();
        idle(); we0 = 1; rd0 = 0; wd0 = 32'hFFFF_FFFF; set_rs(0, 0); step();
        idle(); set_rs(0, 0); set_rs(1, 5); step();
        // T3: dual-write conflict and independent lanes
        idle(); we0 = 1; we1 = 1; rd0 = 7; rd1 = 7; wd0 = 32'h11; wd1 = 32'h22; set_rs(0, 7); step();
        idle(); set_rs(0, 7); step();
        idle(); we0 = 1; we1 = 1; rd0 = 3; rd1 = 4; wd0 = 32'hAA; wd1 = 32'hBB; set_rs(0, 3); set_rs(1, 4); step();
        idle(); set_rs(0, 3); set_rs(1, 4); step();
        // T4: same-cycle forwarding vs stored value
        idle(); we1 = 1; rd1 = 9; wd1 = 32'h1234; set_rs(0, 3); set_rs(1, 9); step();
        idle(); set_rs(1, 9); step();
        // T5: fill, then ClearReq with a concurrent write that must be dropped
        for (int i = 1; i < NREG; i++) begin
            idle(); we0 = 1; rd0 = AW'(i); wd0 = XLEN'(i); rand_rs(); step();
        end
        read_all();
        idle(); clear_req = 1; we0 = 1; rd0 = 2; wd0 = 32'h5555; set_rs(0, 2); step();
        for (int c = 0; c < 32; c++) begin
            idle(); rand_rs(); we0 = 1; rd0 = AW'($urandom_range(1, NREG - 1)); wd0 = $urandom; step();
        end
        read_all();
        // T6: rst at clear step 10 restarts the sequence; writes during clear ignored
        for (int i = 1; i < NREG; i++) begin
            idle(); we1 = 1; rd1 = AW'(i); wd1 = $urandom; step();
        end
        idle(); clear_req = 1; step();
        for (int c = 0; c < 9; c++) begin idle(); rand_rs(); step(); end
        idle(); rst = 1; step();
        for (int c = 0; c < 33; c++) begin
            idle(); rand_rs(); we0 = 1; we1 = 1;
            rd0 = AW'($urandom_range(0, NREG - 1)); rd1 = AW'($urandom_range(0, NREG - 1));
            wd0 = $urandom; wd1 = $urandom; step();
        end
        read_all();
        // Random traffic with occasional clear requests
        for (int c = 0; c < 600; c++) begin
            idle(); rand_rs();
            we0 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
            rd0 = AW'($urandom_range(0, NREG - 1)); rd1 = AW'($urandom_range(0, NREG - 1));
            if ($urandom_range(0, 3) == 0) rd1 = rd0;
            wd0 = $urandom; wd1 = $urandom;
            clear_req = ($urandom_range(0, 99) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        idle();
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
